// File: rtl/pass_entry.sv
// pass_entry: keypad front end of the digital lock.
// Collects three BCD digits from single-cycle key strobes into pass_in,
// compares them against the stored pass_set, and sequences the lock through
// LOCKED / OPEN / SET / LOCKOUT with retry counting and a timed lockout.
module pass_entry #(
  parameter logic [11:0] DEFAULT_PASS   = 12'h123,
  parameter int          MAX_TRIES      = 3,
  parameter int          LOCKOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [11:0] pass_in,
  output logic [11:0] pass_set,
  output logic        mode,
  output logic        L,
  output logic        unlock_pulse,
  output logic        err_pulse,
  output logic        lockout
);

  localparam logic [1:0] ST_LOCKED  = 2'd0;
  localparam logic [1:0] ST_OPEN    = 2'd1;
  localparam logic [1:0] ST_SET     = 2'd2;
  localparam logic [1:0] ST_LOCKOUT = 2'd3;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [3:0] KEY_SET   = 4'hC;
  localparam logic [3:0] KEY_LOCK  = 4'hD;

  // The timer only ever holds LOCKOUT_CYCLES-1 down to 0.
  localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD  = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
  localparam logic [3:0]    TRIES_LIMIT = 4'(MAX_TRIES);

  logic [1:0]    state;
  logic [1:0]    digit_cnt;
  logic [3:0]    tries;
  logic [TW-1:0] lock_timer;

  logic [1:0]    state_nx;
  logic [11:0]   pass_in_nx;
  logic [11:0]   pass_set_nx;
  logic [1:0]    cnt_nx;
  logic [3:0]    tries_nx;
  logic [TW-1:0] timer_nx;
  logic          unlock_nx;
  logic          err_nx;

  logic          is_digit;
  logic          entry_full;
  logic          code_match;
  logic [3:0]    tries_inc;

  assign is_digit   = (key_code <= 4'd9);
  assign entry_full = (digit_cnt == 2'd3);
  assign code_match = (pass_in == pass_set);
  // Retry counter saturates instead of wrapping back to zero.
  assign tries_inc  = (tries == 4'hF) ? tries : tries + 4'd1;

  // Next-state decode: one key event (or one lockout tick) per cycle.
  always_comb begin
    state_nx    = state;
    pass_in_nx  = pass_in;
    pass_set_nx = pass_set;
    cnt_nx      = digit_cnt;
    tries_nx    = tries;
    timer_nx    = lock_timer;
    unlock_nx   = 1'b0;
    err_nx      = 1'b0;

    if (state == ST_LOCKOUT) begin
      if (lock_timer == '0) begin
        state_nx = ST_LOCKED;
        tries_nx = 4'd0;
      end else begin
        timer_nx = lock_timer - TIMER_ONE;
      end
    end else if (key_valid) begin
      if (is_digit) begin
        if ((state == ST_LOCKED || state == ST_SET) && !entry_full) begin
          pass_in_nx = {pass_in[7:0], key_code};
          cnt_nx     = digit_cnt + 2'd1;
        end
      end else begin
        case (key_code)
          KEY_CLEAR: begin
            pass_in_nx = 12'h000;
            cnt_nx     = 2'd0;
            if (state == ST_SET) begin
              state_nx = ST_OPEN;
            end
          end
          KEY_ENTER: begin
            if (entry_full && state == ST_LOCKED) begin
              pass_in_nx = 12'h000;
              cnt_nx     = 2'd0;
              if (code_match) begin
                unlock_nx = 1'b1;
                tries_nx  = 4'd0;
                state_nx  = ST_OPEN;
              end else begin
                err_nx   = 1'b1;
                tries_nx = tries_inc;
                if (tries_inc == TRIES_LIMIT) begin
                  state_nx = ST_LOCKOUT;
                  timer_nx = TIMER_LOAD;
                end
              end
            end else if (entry_full && state == ST_SET) begin
              pass_set_nx = pass_in;
              pass_in_nx  = 12'h000;
              cnt_nx      = 2'd0;
              state_nx    = ST_OPEN;
            end
          end
          KEY_SET: begin
            if (state == ST_OPEN) begin
              state_nx   = ST_SET;
              pass_in_nx = 12'h000;
              cnt_nx     = 2'd0;
            end
          end
          KEY_LOCK: begin
            if (state == ST_OPEN || state == ST_SET) begin
              state_nx   = ST_LOCKED;
              pass_in_nx = 12'h000;
              cnt_nx     = 2'd0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // State registers; status flags are registered straight from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_LOCKED;
      pass_in      <= 12'h000;
      pass_set     <= DEFAULT_PASS;
      digit_cnt    <= 2'd0;
      tries        <= 4'd0;
      lock_timer   <= '0;
      mode         <= 1'b0;
      L            <= 1'b1;
      lockout      <= 1'b0;
      unlock_pulse <= 1'b0;
      err_pulse    <= 1'b0;
    end else begin
      state        <= state_nx;
      pass_in      <= pass_in_nx;
      pass_set     <= pass_set_nx;
      digit_cnt    <= cnt_nx;
      tries        <= tries_nx;
      lock_timer   <= timer_nx;
      mode         <= (state_nx == ST_SET);
      L            <= (state_nx == ST_LOCKED) || (state_nx == ST_LOCKOUT);
      lockout      <= (state_nx == ST_LOCKOUT);
      unlock_pulse <= unlock_nx;
      err_pulse    <= err_nx;
    end
  end

endmodule

// File: tb/tb_pass_entry.sv
// tb_pass_entry: directed scenarios plus randomized key traffic for pass_entry,
// checked every cycle against a queue-based behavioural model of the lock.
module tb_pass_entry;

  localparam int          LC = 8;
  localparam int          MT = 3;
  localparam logic [11:0] DP = 12'h123;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [11:0] pass_in;
  logic [11:0] pass_set;
  logic        mode;
  logic        L;
  logic        unlock_pulse;
  logic        err_pulse;
  logic        lockout;

  int total = 0;
  int bad   = 0;

  // Behavioural model: entered digits kept as a plain list of integers.
  bit          m_locked;
  bit          m_mode;
  bit          m_lockout;
  bit          m_unlock;
  bit          m_err;
  int          m_tries;
  int          m_timer;
  int          m_digits[$];
  logic [11:0] m_set;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  pass_entry #(
    .DEFAULT_PASS  (DP),
    .MAX_TRIES     (MT),
    .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .pass_in      (pass_in),
    .pass_set     (pass_set),
    .mode         (mode),
    .L            (L),
    .unlock_pulse (unlock_pulse),
    .err_pulse    (err_pulse),
    .lockout      (lockout)
  );

  function automatic int entryValue();
    int v = 0;
    foreach (m_digits[i]) v = v * 16 + m_digits[i];
    return v;
  endfunction

  task automatic modelReset();
    m_locked  = 1'b1;
    m_mode    = 1'b0;
    m_lockout = 1'b0;
    m_unlock  = 1'b0;
    m_err     = 1'b0;
    m_tries   = 0;
    m_timer   = 0;
    m_set     = DP;
    m_digits.delete();
  endtask

  task automatic modelStep(input logic v, input logic [3:0] c);
    int val;
    m_unlock = 1'b0;
    m_err    = 1'b0;
    if (m_lockout) begin
      if (m_timer == 0) begin
        m_lockout = 1'b0;
        m_tries   = 0;
      end else begin
        m_timer--;
      end
    end else if (v) begin
      if (c <= 4'd9) begin
        if ((m_locked || m_mode) && m_digits.size() < 3) m_digits.push_back(int'(c));
      end else if (c == 4'hA) begin
        m_digits.delete();
        m_mode = 1'b0;
      end else if (c == 4'hB) begin
        if (m_digits.size() == 3 && (m_mode || m_locked)) begin
          val = entryValue();
          m_digits.delete();
          if (m_mode) begin
            m_set  = 12'(val);
            m_mode = 1'b0;
          end else if (val == int'(m_set)) begin
            m_locked = 1'b0;
            m_unlock = 1'b1;
            m_tries  = 0;
          end else begin
            m_err = 1'b1;
            if (m_tries < 15) m_tries++;
            if (m_tries == MT) begin
              m_lockout = 1'b1;
              m_timer   = LC - 1;
            end
          end
        end
      end else if (c == 4'hC) begin
        if (!m_locked && !m_mode) begin
          m_mode = 1'b1;
          m_digits.delete();
        end
      end else if (c == 4'hD) begin
        if (!m_locked) begin
          m_locked = 1'b1;
          m_mode   = 1'b0;
          m_digits.delete();
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("pass_in",      32'(pass_in),      32'(entryValue()));
    checkOutput("pass_set",     32'(pass_set),     32'(m_set));
    checkOutput("mode",         32'(mode),         32'(m_mode));
    checkOutput("L",            32'(L),            32'(m_locked));
    checkOutput("unlock_pulse", 32'(unlock_pulse), 32'(m_unlock));
    checkOutput("err_pulse",    32'(err_pulse),    32'(m_err));
    checkOutput("lockout",      32'(lockout),      32'(m_lockout));
  endtask

  // Drive one cycle of input, advance the model on the edge, check just after.
  task automatic applyStimulus(input logic v, input logic [3:0] c);
    @(negedge clk);
    key_valid = v;
    key_code  = c;
    @(posedge clk);
    modelStep(v, c);
    #1;
    checkAll();
  endtask

  task automatic pressKey(input logic [3:0] c);
    applyStimulus(1'b1, c);
  endtask

  task automatic applyReset();
    @(negedge clk);
    key_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Hard stop in case anything stalls the run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] scenario 1: default code unlocks");
    pressKey(4'h1); checkOutput("t1_pin_001", 32'(pass_in), 32'h001);
    pressKey(4'h2); checkOutput("t1_pin_012", 32'(pass_in), 32'h012);
    pressKey(4'h3); checkOutput("t1_pin_123", 32'(pass_in), 32'h123);
    pressKey(4'hB);
    checkOutput("t1_unlock", 32'(unlock_pulse), 32'd1);
    checkOutput("t1_open",   32'(L),            32'd0);
    checkOutput("t1_pin_clr", 32'(pass_in),     32'h000);
    applyStimulus(1'b0, 4'h0);
    checkOutput("t1_unlock_once", 32'(unlock_pulse), 32'd0);

    $display("[TB] scenario 2: wrong code with extra digit");
    pressKey(4'hD);
    pressKey(4'h4); pressKey(4'h5); pressKey(4'h6); pressKey(4'h7);
    checkOutput("t2_pin_456", 32'(pass_in), 32'h456);
    pressKey(4'hB);
    checkOutput("t2_err",    32'(err_pulse), 32'd1);
    checkOutput("t2_locked", 32'(L),         32'd1);

    $display("[TB] scenario 3: lockout after repeated errors");
    pressKey(4'h1); pressKey(4'h2); pressKey(4'h3); pressKey(4'hB);
    pressKey(4'hD);
    for (int t = 0; t < 3; t++) begin
      pressKey(4'h9); pressKey(4'h9); pressKey(4'h9); pressKey(4'hB);
      checkOutput("t3_err", 32'(err_pulse), 32'd1);
      checkOutput("t3_lockout", 32'(lockout), (t == 2) ? 32'd1 : 32'd0);
    end
    cnt = 1;
    for (int i = 0; i < 50; i++) begin
      pressKey(4'($urandom_range(0, 15)));
      if (!lockout) break;
      cnt++;
    end
    checkOutput("t3_lockout_len", 32'(cnt), 32'(LC));
    pressKey(4'h1); pressKey(4'h2); pressKey(4'h3); pressKey(4'hB);
    checkOutput("t3_unlock", 32'(unlock_pulse), 32'd1);

    $display("[TB] scenario 4: change code");
    pressKey(4'hC);
    checkOutput("t4_mode", 32'(mode), 32'd1);
    pressKey(4'h0); pressKey(4'hF); pressKey(4'h4); pressKey(4'h2);
    checkOutput("t4_pin_042", 32'(pass_in), 32'h042);
    pressKey(4'hB);
    checkOutput("t4_set_042", 32'(pass_set), 32'h042);
    checkOutput("t4_mode_off", 32'(mode), 32'd0);
    checkOutput("t4_open", 32'(L), 32'd0);
    pressKey(4'hD);
    pressKey(4'h0); pressKey(4'h4); pressKey(4'h2); pressKey(4'hB);
    checkOutput("t4_unlock", 32'(unlock_pulse), 32'd1);

    $display("[TB] scenario 5: cancelled change and short entry");
    applyReset();
    pressKey(4'h1); pressKey(4'h2); pressKey(4'h3); pressKey(4'hB);
    pressKey(4'hC); pressKey(4'h7); pressKey(4'h7); pressKey(4'hA);
    checkOutput("t5_set_kept", 32'(pass_set), 32'h123);
    checkOutput("t5_mode_off", 32'(mode), 32'd0);
    checkOutput("t5_open", 32'(L), 32'd0);
    pressKey(4'hD);
    pressKey(4'h1); pressKey(4'h2); pressKey(4'hB);
    checkOutput("t5_no_err", 32'(err_pulse), 32'd0);
    checkOutput("t5_pin_kept", 32'(pass_in), 32'h012);
    pressKey(4'h3); pressKey(4'hB);
    checkOutput("t5_unlock", 32'(unlock_pulse), 32'd1);

    $display("[TB] scenario 6: asynchronous reset mid change");
    pressKey(4'hC); pressKey(4'h0); pressKey(4'h4); pressKey(4'h2); pressKey(4'hB);
    pressKey(4'hC); pressKey(4'h1);
    applyReset();
    checkOutput("t6_set", 32'(pass_set), 32'h123);
    checkOutput("t6_L",   32'(L),        32'd1);
    checkOutput("t6_mode", 32'(mode),    32'd0);
    checkOutput("t6_pin", 32'(pass_in),  32'h000);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        applyReset();
      end else if (!m_lockout && m_locked && $urandom_range(0, 9) == 0) begin
        pressKey(4'hA);
        for (int d = 2; d >= 0; d--) pressKey(m_set[d*4 +: 4]);
        pressKey(4'hB);
      end else if ($urandom_range(0, 3) == 0) begin
        applyStimulus(1'b0, 4'($urandom_range(0, 15)));
      end else begin
        applyStimulus(1'b1, 4'($urandom_range(0, 15)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
